serial_adder: RTL and testbench

//  Bit-serial N-bit adder built around a single full-adder cell (sum = a^b^c,

---
 rtl/serial_adder.sv | 101 ++++++++++
 tb/tb_serial_adder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell, a registered carry and N RUN cycles per add.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
   output logic         cout,
   output logic         ovf
`else
   output logic         cout
`endif
);

   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Full-adder cell: {carry, sum}
   function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

   logic [1:0]    state;
   logic [N-1:0]  a_sh;
   logic [N-1:0]  b_sh;
   logic          carry;
   logic [CW-1:0] cnt;
   logic [1:0]    fa_out;
   logic          last;

   assign fa_out = fa(a_sh[0], b_sh[0], carry);
   assign last   = (cnt == CW'(N - 1));
   assign done   = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a_in;
                  b_sh  <= b_in;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
`ifdef SERIAL_ADD_OVF_EN
                  ovf   <= 1'b0;
`endif
               end
            end
            RUN: begin
               a_sh  <= {1'b0, a_sh[N-1:1]};
               b_sh  <= {1'b0, b_sh[N-1:1]};
               sum   <= {fa_out[0], sum[N-1:1]};
               carry <= fa_out[1];
               cnt   <= cnt + CW'(1);
               if (last) begin
                  cout  <= fa_out[1];
                  state <= DONE;
`ifdef SERIAL_ADD_OVF_EN
                  // carry still holds the carry into the MSB at this edge
                  ovf   <= carry ^ fa_out[1];
`endif
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (N=8); ovf checks follow SERIAL_ADD_OVF_EN.
module tb_serial_adder;

   localparam int N = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] a_in;
   logic [N-1:0] b_in;
   logic         cin;
   logic         busy;
   logic         done;
   logic [N-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   int total;
   int bad;

   serial_adder #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a_in  (a_in),
      .b_in  (b_in),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
      .cout  (cout),
      .ovf   (ovf)
`else
      .cout  (cout)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic [N-1:0] es, input logic ec, input logic eo);
      chk({tag, " sum"}, 32'(sum), 32'(es));
      chk({tag, " cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
      chk({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
      if (eo === 1'bx) $display("note: unexpected x in expected ovf for %s", tag);
`endif
   endtask

   // One operation from IDLE; poke=1 pulses start during RUN
   task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic ci, input logic [N-1:0] es, input logic ec,
                         input logic eo, input bit poke);
      int n;
      bit got;
      @(posedge clk); #1;
      a_in = a; b_in = b; cin = ci; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a_in = N'($urandom); b_in = N'($urandom); cin = ~ci;
      chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
      chk({tag, " done_early"}, 32'(done), 32'd0);
      n = 0;
      got = 1'b0;
      for (int i = 1; i <= N + 4 && !got; i++) begin
         @(posedge clk); #1;
         if (poke && i == 2) start = 1'b1;
         if (poke && i == 3) start = 1'b0;
         if (done) begin
            got = 1'b1;
            n = i;
         end
      end
      chk({tag, " latency"}, 32'(n), 32'(N));
      chk_res(tag, es, ec, eo);
      @(posedge clk); #1;
      chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, " busy_idle"}, 32'(busy), 32'd0);
      chk_res({tag, " held"}, es, ec, eo);
   endtask

   logic [N-1:0] bb_a  [3] = '{8'h11, 8'h80, 8'hA5};
   logic [N-1:0] bb_b  [3] = '{8'h22, 8'h80, 8'h5A};
   logic         bb_c  [3] = '{1'b0, 1'b0, 1'b1};
   logic [N-1:0] bb_s  [3] = '{8'h33, 8'h00, 8'h00};
   logic         bb_co [3] = '{1'b0, 1'b1, 1'b1};
   logic         bb_ov [3] = '{1'b0, 1'b1, 1'b0};

   initial begin
      int n;
      int dones;
      bit got;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      cin   = 1'b0;
      #1;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk_res("rst", 8'h00, 1'b0, 1'b0);
      #21 rst_n = 1'b1;

      run_op("t1", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
      run_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      run_op("t3", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);

      // back-to-back with start held; operands swapped during DONE for the next IDLE
      @(posedge clk); #1;
      a_in = bb_a[0]; b_in = bb_b[0]; cin = bb_c[0]; start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         got = 1'b0;
         for (int i = 1; i <= N + 4 && !got; i++) begin
            @(posedge clk); #1;
            if (done) begin
               got = 1'b1;
               n = i;
            end
         end
         chk($sformatf("t5 period%0d", k), 32'(n), (k == 0) ? 32'(N + 1) : 32'(N + 2));
         chk_res($sformatf("t5 op%0d", k), bb_s[k], bb_co[k], bb_ov[k]);
         if (k < 2) begin
            a_in = bb_a[k+1]; b_in = bb_b[k+1]; cin = bb_c[k+1];
         end else begin
            start = 1'b0;
         end
      end
      @(posedge clk); #1;
      chk("t5 done_clear", 32'(done), 32'd0);

      run_op("t4", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);

      // reset during RUN cycle 4
      @(posedge clk); #1;
      a_in = 8'hFF; b_in = 8'h00; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t6 busy", 32'(busy), 32'd0);
      chk("t6 done", 32'(done), 32'd0);
      chk("t6 sum", 32'(sum), 32'd0);
      chk("t6 cout", 32'(cout), 32'd0);
      #16 rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 2 * N + 4; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      chk("t6 no_done", 32'(dones), 32'd0);
      chk("t6 idle_busy", 32'(busy), 32'd0);

      run_op("t7", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
